// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Multiply and divide variants run through the iterative datapath.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Two's complement negate when neg is set, pass-through otherwise.
  function automatic logic [31:0] neg_cond32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are processed one bit per cycle; signs are reapplied in FIX.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [31:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic          is_mul_q, is_mul_d;
  logic          neg_q, neg_d;      // negate product / quotient
  logic          rneg_q, rneg_d;    // negate remainder (dividend was negative)
  logic          bzero_q, bzero_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          sa_in, sb_in;
  logic [32:0]   mul_sum;
  logic [32:0]   div_diff;
  logic [63:0]   step_acc;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rem_fix;

  assign sa_in = is_signed_op(op) & a[31];
  assign sb_in = is_signed_op(op) & b[31];

  // Shift-add: conditionally add multiplicand to the upper half, then shift right.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

  // Restoring divide: trial-subtract divisor from the left-shifted remainder;
  // bit 32 of the difference is the borrow (remainder stays below 2*divisor).
  assign div_diff = acc_q[63:31] - {1'b0, opnd_q};

  assign step_acc = is_mul_q      ? {mul_sum, acc_q[31:1]} :
                    div_diff[32]  ? {acc_q[62:0], 1'b0} :
                                    {div_diff[31:0], acc_q[30:0], 1'b1};

  // Sign correction; divide by zero yields all-ones quotient and the dividend as remainder.
  assign prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = bzero_q ? 32'hFFFF_FFFF : neg_cond32(acc_q[31:0], neg_q);
  assign rem_fix  = neg_cond32(acc_q[63:32], rneg_q);

  // Next-state logic for the FSM, datapath and HI/LO registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (is_iter_op(op)) begin
            state_d  = ST_CALC;
            busy_d   = 1'b1;
            cnt_d    = CNT_LOAD;
            acc_d    = {32'd0, neg_cond32(a, sa_in)};
            opnd_d   = neg_cond32(b, sb_in);
            is_mul_d = (op == OP_MULT) || (op == OP_MULTU);
            neg_d    = sa_in ^ sb_in;
            rneg_d   = sa_in;
            bzero_d  = (b == 32'd0);
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        if (is_mul_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A pipeline kill abandons everything, including a same-cycle start or HI/LO write.
    if (flush) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State register with asynchronous clear of FSM, counter, HI/LO and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus pushes expected {hi,lo} from an
// arithmetic reference model; a monitor pops and compares on every done.
module tb_muldiv;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  muldiv #(.ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model: plain 64-bit / language division semantics.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          p;
    longint unsigned pu;
    int              q;
    int              r;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      3'd1: begin
        pu = {32'd0, x} * {32'd0, y};
        return pu;
      end
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("done_without_request", {63'd0, done}, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("scoreboard", {hi, lo}, mon_exp);
      end
    end
  end

  // Wait (bounded) for done, sampling 1 time unit after each rising edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 60);
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit lat);
    int          n;
    logic [63:0] e;
    e = 64'd0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (o <= 3'd3) begin
      e = model(o, x, y);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o == 3'd4 || o == 3'd5) begin
      if (o == 3'd4) exp_hi = x;
      else exp_lo = x;
      chk("move_hilo", {hi, lo}, {exp_hi, exp_lo});
      chk("move_busy", {63'd0, busy}, 64'd0);
    end else if (o <= 3'd3) begin
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      wait_done(n);
      // done is seen after 33 further edges: 34 edges counting the accepting one
      if (lat) chk("latency", 64'(n), 64'(ITER + 1));
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      chk("result", {hi, lo}, e);
    end else begin
      chk("badop_busy", {63'd0, busy}, 64'd0);
      chk("badop_hilo", {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  initial begin
    int          n;
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;

    // Reset state
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases (back-to-back: each next start lands in DONE)
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd3, 1'b1);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd0, 1'b1);
    chk("divu_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b1);
    chk("div_by_zero", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // Start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd1234; b = 32'd5678;
    sb_q.push_back(model(3'd1, 32'd1234, 32'd5678));
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    chk("ignored_start_latency", 64'(n + 5), 64'(ITER + 1));
    chk("ignored_start_result", {hi, lo}, 64'd7006652);
    exp_hi = hi; exp_lo = lo;
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_idle", {63'd0, busy}, 64'd0);

    // MTHI, then a flushed DIVU
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hilo", {hi, lo}, {32'h1234_5678, exp_lo});

    // Flush beats a same-cycle start
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("flush_vs_mtlo", {hi, lo}, {exp_hi, exp_lo});
    @(negedge clk);
    op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_vs_mult", {63'd0, busy}, 64'd0);

    // Undefined op codes do nothing
    run_op(3'd6, 32'hAAAA_5555, 32'd1, 1'b0);
    run_op(3'd7, 32'h5555_AAAA, 32'd1, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op(o, x, y, 1'b1);
    end

    // Asynchronous reset during CALC
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0006_789A;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'd3, 32'd5, 1'b1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
